// File: rtl/xnor_conv_window_engine.sv
// KxK XNOR-popcount convolution engine: column-streaming sliding window with valid/ready.
// Optional sign binarization (thresh/out_bit) is enabled by defining XNOR_CONV_BINARIZE_EN.
module xnor_conv_window_engine #(
    parameter int K     = 3,
    parameter int SUM_W = $clog2(K*K)+2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    weight_load,
    input  logic [K*K-1:0]          weight_in,
    input  logic                    row_start,
    input  logic                    col_valid,
    input  logic [K-1:0]            col_in,
    output logic                    col_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [SUM_W-1:0] out_sum
`ifdef XNOR_CONV_BINARIZE_EN
    ,
    input  logic signed [SUM_W-1:0] thresh,
    output logic                    out_bit
`endif
);

    localparam int N     = K*K;
    localparam int POP_W = $clog2(N+1);
    localparam int CNT_W = $clog2(K+1);

    logic [N-1:0]     weight_q;
    logic [N-1:0]     win_q;
    logic [N-1:0]     win_shift;
    logic [N-1:0]     match;
    logic [CNT_W-1:0] fill_q;
    logic [CNT_W-1:0] fill_next;
    logic [POP_W-1:0] pop;
    logic [SUM_W-1:0] sum_c;
    logic             accept;
    logic             full_next;

    always_comb begin
        col_ready = !weight_load && (!out_valid || out_ready);
        accept    = col_valid && col_ready;
    end

    // Window bit r*K+c; column 0 is oldest, new column enters at K-1.
    always_comb begin
        win_shift = '0;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
                if (c == K-1)
                    win_shift[r*K+c] = col_in[r];
                else
                    win_shift[r*K+c] = win_q[r*K+c+1];
            end
        end
    end

    always_comb begin
        if (row_start)
            fill_next = CNT_W'(1);
        else if (fill_q == CNT_W'(K))
            fill_next = fill_q;
        else
            fill_next = fill_q + CNT_W'(1);
        full_next = (fill_next == CNT_W'(K));
    end

    always_comb begin
        match = ~(win_shift ^ weight_q);
        pop   = '0;
        for (int unsigned i = 0; i < N; i++)
            pop = pop + POP_W'(match[i]);
        // Modular subtraction yields the two's-complement of 2*pop - K*K.
        sum_c = SUM_W'({pop, 1'b0}) - SUM_W'(N);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            weight_q  <= '0;
            win_q     <= '0;
            fill_q    <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
`ifdef XNOR_CONV_BINARIZE_EN
            out_bit   <= 1'b0;
`endif
        end else if (weight_load) begin
            weight_q  <= weight_in;
            win_q     <= '0;
            fill_q    <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            win_q  <= win_shift;
            fill_q <= fill_next;
            if (full_next) begin
                out_valid <= 1'b1;
                out_sum   <= sum_c;
`ifdef XNOR_CONV_BINARIZE_EN
                out_bit   <= ($signed(sum_c) >= thresh);
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xnor_conv_window_engine.sv
// Self-checking bench for xnor_conv_window_engine: directed vector table, random stream
// against a queue-based reference model, and a K=5 instance for the wider kernel.
module tb_xnor_conv_window_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, wl, rs, cv, ordy;
    logic [8:0]        wi;
    logic [2:0]        ci;
    logic              col_ready, out_valid;
    logic signed [4:0] out_sum;

    xnor_conv_window_engine dut (
        .clk(clk), .rst(rst), .weight_load(wl), .weight_in(wi), .row_start(rs),
        .col_valid(cv), .col_in(ci), .col_ready(col_ready), .out_valid(out_valid),
        .out_ready(ordy), .out_sum(out_sum)
    );

    logic              rst5, wl5, rs5, cv5, ordy5;
    logic [24:0]       wi5;
    logic [4:0]        ci5;
    logic              rdy5, ov5;
    logic signed [6:0] os5;

    xnor_conv_window_engine #(.K(5), .SUM_W(7)) dut5 (
        .clk(clk), .rst(rst5), .weight_load(wl5), .weight_in(wi5), .row_start(rs5),
        .col_valid(cv5), .col_in(ci5), .col_ready(rdy5), .out_valid(ov5),
        .out_ready(ordy5), .out_sum(os5)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: the current row's most recent columns, oldest first.
    logic [8:0] m_w = '0;
    logic [2:0] m_q[$];
    logic       m_valid = 1'b0;
    int         m_sum = 0;

    function automatic int score();
        int pop = 0;
        foreach (m_q[c])
            for (int r = 0; r < 3; r++)
                if (m_q[c][r] == m_w[r*3+c]) pop++;
        return 2*pop - 9;
    endfunction

    task automatic cycle(input logic a_rst, input logic a_wl, input logic [8:0] a_w,
                         input logic a_rs, input logic a_cv, input logic [2:0] a_col,
                         input logic a_ordy, output int rdy_dut, output int rdy_mod);
        rst = a_rst; wl = a_wl; wi = a_w; rs = a_rs; cv = a_cv; ci = a_col; ordy = a_ordy;
        #1;
        rdy_dut = int'(col_ready);
        rdy_mod = (!a_wl && (!m_valid || a_ordy)) ? 1 : 0;
        @(posedge clk);
        if (!a_rst) begin
            m_w = '0; m_q.delete(); m_valid = 1'b0; m_sum = 0;
        end else if (a_wl) begin
            m_w = a_w; m_q.delete(); m_valid = 1'b0;
        end else if (a_cv && rdy_mod == 1) begin
            if (a_rs) m_q.delete();
            m_q.push_back(a_col);
            if (m_q.size() > 3) void'(m_q.pop_front());
            if (m_q.size() == 3) begin
                m_valid = 1'b1;
                m_sum   = score();
            end else begin
                m_valid = 1'b0;
            end
        end else if (m_valid && a_ordy) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    typedef struct {
        logic       rst, wl;
        logic [8:0] w;
        logic       rs, cv;
        logic [2:0] col;
        logic       ordy;
        int         er;   // expected col_ready before the edge, -1 = unchecked
        int         ev;
        int         es;
        logic       cs;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic a_rst, input logic a_wl, input logic [8:0] a_w,
                       input logic a_rs, input logic a_cv, input logic [2:0] a_col,
                       input logic a_ordy, input int er, input int ev, input int es,
                       input logic cs);
        vec_t v;
        v.rst = a_rst; v.wl = a_wl; v.w = a_w; v.rs = a_rs; v.cv = a_cv; v.col = a_col;
        v.ordy = a_ordy; v.er = er; v.ev = ev; v.es = es; v.cs = cs;
        tbl.push_back(v);
    endtask

    task automatic step5(input logic a_rst, input logic a_wl, input logic [24:0] a_w,
                         input logic a_cv, input logic [4:0] a_col);
        rst5 = a_rst; wl5 = a_wl; wi5 = a_w; cv5 = a_cv; ci5 = a_col;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rd, rm;
        logic a_rst, a_wl, a_rs, a_cv, a_ordy;
        logic [8:0] a_w;
        logic [2:0] a_col;

        rst5 = 1'b0; wl5 = 1'b0; rs5 = 1'b0; cv5 = 1'b0; ordy5 = 1'b1; wi5 = '0; ci5 = '0;

        //   rst wl  w       rs cv col     ordy er  ev es  cs
        add(0, 0, 9'h000, 0, 0, 3'b000, 1, -1, 0,  0, 1);  // reset
        add(1, 1, 9'h1FF, 0, 0, 3'b000, 1,  0, 0,  0, 0);  // load all-ones
        add(1, 0, 9'h000, 0, 1, 3'b111, 1,  1, 0,  0, 0);
        add(1, 0, 9'h000, 0, 1, 3'b111, 1,  1, 0,  0, 0);
        add(1, 0, 9'h000, 0, 1, 3'b111, 1,  1, 1,  9, 1);  // first result +9
        add(1, 0, 9'h000, 0, 1, 3'b000, 1,  1, 1,  3, 1);
        add(1, 0, 9'h000, 0, 1, 3'b000, 1,  1, 1, -3, 1);
        add(1, 0, 9'h000, 0, 1, 3'b000, 1,  1, 1, -9, 1);  // all mismatch -9
        add(1, 1, 9'h1FF, 0, 1, 3'b000, 1,  0, 0,  0, 0);  // load wins over column
        add(1, 0, 9'h000, 0, 1, 3'b101, 1,  1, 0,  0, 0);
        add(1, 0, 9'h000, 0, 1, 3'b010, 1,  1, 0,  0, 0);
        add(1, 0, 9'h000, 0, 1, 3'b101, 1,  1, 1,  1, 1);  // pop 5 -> +1
        add(1, 0, 9'h000, 0, 1, 3'b111, 1,  1, 1,  3, 1);  // pop 6 -> +3
        add(1, 0, 9'h000, 0, 0, 3'b000, 1,  1, 0,  3, 1);  // drained, sum holds
        add(0, 0, 9'h000, 0, 1, 3'b111, 1,  1, 0,  0, 1);  // mid-stream reset
        add(1, 0, 9'h000, 0, 1, 3'b000, 1,  1, 0,  0, 0);
        add(1, 0, 9'h000, 0, 1, 3'b000, 1,  1, 0,  0, 0);
        add(1, 0, 9'h000, 0, 1, 3'b000, 1,  1, 1,  9, 1);  // zero weights, zero cols
        for (int i = 0; i < 5; i++)
            add(1, 0, 9'h000, 0, 1, 3'b111, 0,  0, 1,  9, 1);  // backpressure hold
        add(1, 0, 9'h000, 0, 1, 3'b111, 1,  1, 1,  3, 1);
        add(1, 0, 9'h000, 0, 1, 3'b000, 1,  1, 1,  3, 1);
        add(1, 0, 9'h000, 0, 0, 3'b000, 1,  1, 0,  3, 1);
        add(1, 0, 9'h000, 1, 1, 3'b111, 1,  1, 0,  0, 0);  // row restart
        add(1, 0, 9'h000, 0, 1, 3'b111, 1,  1, 0,  0, 0);
        add(1, 0, 9'h000, 0, 1, 3'b111, 1,  1, 1, -9, 1);
        add(1, 0, 9'h000, 1, 0, 3'b000, 1,  1, 0, -9, 1);  // row_start alone ignored
        add(1, 0, 9'h000, 0, 1, 3'b000, 1,  1, 1, -3, 1);

        foreach (tbl[i]) begin
            cycle(tbl[i].rst, tbl[i].wl, tbl[i].w, tbl[i].rs, tbl[i].cv, tbl[i].col,
                  tbl[i].ordy, rd, rm);
            if (tbl[i].er >= 0) check($sformatf("vec%0d_ready", i), rd, tbl[i].er);
            check($sformatf("vec%0d_valid", i), int'(out_valid), tbl[i].ev);
            if (tbl[i].cs) check($sformatf("vec%0d_sum", i), int'(out_sum), tbl[i].es);
        end

        for (int i = 0; i < 600; i++) begin
            a_rst  = ($urandom_range(63) != 0);
            a_wl   = ($urandom_range(31) == 0);
            a_w    = 9'($urandom);
            a_rs   = ($urandom_range(7) == 0);
            a_cv   = ($urandom_range(3) != 0);
            a_col  = 3'($urandom);
            a_ordy = ($urandom_range(3) != 0);
            cycle(a_rst, a_wl, a_w, a_rs, a_cv, a_col, a_ordy, rd, rm);
            check($sformatf("rnd%0d_ready", i), rd, rm);
            check($sformatf("rnd%0d_valid", i), int'(out_valid), int'(m_valid));
            if (m_valid || !a_rst)
                check($sformatf("rnd%0d_sum", i), int'(out_sum), m_sum);
        end

        step5(1'b0, 1'b0, '0, 1'b0, '0);
        check("k5_reset_valid", int'(ov5), 0);
        check("k5_reset_sum", int'(os5), 0);
        step5(1'b1, 1'b1, 25'h1FF_FFFF, 1'b0, '0);
        for (int i = 1; i <= 5; i++) begin
            step5(1'b1, 1'b0, '0, 1'b1, 5'h1F);
            check($sformatf("k5_match_valid%0d", i), int'(ov5), (i == 5) ? 1 : 0);
        end
        check("k5_match_sum", int'(os5), 25);
        for (int i = 1; i <= 5; i++)
            step5(1'b1, 1'b0, '0, 1'b1, 5'h00);
        check("k5_mismatch_valid", int'(ov5), 1);
        check("k5_mismatch_sum", int'(os5), -25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xnor_conv_window_engine.md
Name: xnor_conv_window_engine

Overview:
Parametrised KxK binary (XNOR-popcount) convolution engine. Replaces the fixed 3x3 PE array and its free-running start counter with a column-streaming sliding window. Accepts one K-bit activation column per beat from the line buffer and emits one signed partial sum per accepted beat once the window is full. Adds valid/ready backpressure, row restart, and parametrised kernel size and output width.

Parameters:
K, 3, kernel edge length; legal range 2..7.
SUM_W, $clog2(K*K)+2, output width (signed); must hold the range -K*K..+K*K (5 for K=3).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-low reset.
weight_load  input  1  loads weights and flushes the window; highest priority after rst.
weight_in  input  K*K  kernel bits; bit r*K+c is row r, column c (c=0 is the oldest column).
row_start  input  1  marks the first column of a new image row; restarts warm-up.
col_valid  input  1  an activation column is offered.
col_in  input  K  activation column; bit r is kernel row r.
col_ready  output  1  the engine can accept a column this cycle.
out_valid  output  1  out_sum holds a result.
out_ready  input  1  the consumer accepts out_sum.
out_sum  output  SUM_W  signed result, 2*popcount - K*K.

Behaviour:
- Reset (rst=0 at a clock edge): weight register=0, window=0, fill count=0, out_valid=0, out_sum=0. Reset overrides every other input, including during an active stream.
- weight_load=1: weight register<=weight_in. The window, fill count and out_valid clear. Any pending result is dropped. col_valid is ignored that cycle and col_ready=0.
- col_ready = !weight_load && (!out_valid || out_ready). The output is a 1-deep register; full throughput when out_ready is held high.
- Accept = col_valid && col_ready. On accept, the window shifts: column c receives column c+1, and column K-1 receives col_in.
- Fill count saturates at K. With row_start on an accepted beat, the count becomes 1, so the column starts the new row. Older columns stay in the window but are not counted.
- Result: compute the post-shift window. If the post-shift count equals K, then pop = number of (r,c) positions where window[r][c] XNOR weight[r*K+c] = 1. Register out_sum<=2*pop-K*K (sign-extended to SUM_W) and set out_valid<=1. Latency: 1 cycle from the accepting edge.
- If an accepted beat yields a count < K (warm-up), out_valid<=0 when out_ready=1 or when no result is pending. With K=3, the first result follows the 3rd accepted column of a row, then one result per column.
- out_valid && out_ready with no new result that cycle: out_valid<=0, and out_sum holds its last value.
- out_valid && !out_ready: out_sum and out_valid hold, col_ready=0, and the window is frozen.
- row_start without col_valid has no effect.
- Simultaneous weight_load and col_valid: weight_load wins and the column is lost. Upstream must not do this.
- All arithmetic is unsigned popcount (width $clog2(K*K+1)) followed by a signed conversion. No overflow is possible for the legal SUM_W.

Optional Feature:
Macro XNOR_CONV_BINARIZE_EN.
- Defined: adds input thresh (SUM_W, signed) and output out_bit (1). out_bit is registered alongside out_sum as (2*pop-K*K >= thresh). It shares out_valid and resets to 0. This gives the sign activation that feeds the next layer.
- Undefined: neither port exists, and behaviour is exactly as above.

Test Plan:
- K=3: load weight 9'h1FF, send 3 columns of 3'b111 with out_ready=1. Expect no valid on beats 1-2, then out_sum=+9 one cycle after beat 3. Columns 3'b000 give out_sum=-9.
- K=3: weights 9'h1FF, columns 3'b101, 3'b010, 3'b101 give pop=5 and out_sum=+1. A 4th column 3'b111 gives window {010,101,111}, pop=6, out_sum=+3.
- Backpressure: hold out_ready=0 after the first result. Expect col_ready=0 and out_sum stable for 5 cycles, with no column consumed. Release out_ready, and the next result follows in order.
- row_start on the 5th column of a stream: expect no out_valid for that beat and the next one. The next result appears on the 3rd column of the new row.
- Drive rst=0 for one cycle mid-stream, or pulse weight_load mid-stream. Expect out_valid=0 and out_sum=0 after reset, and a fresh 3-column warm-up before the next result.
- K=5, SUM_W=7: all-match stream gives out_sum=+25, and all-mismatch gives -25. With XNOR_CONV_BINARIZE_EN and thresh=0, out_bit=1 and out_bit=0 respectively.
